// File: rtl/funcn_sweep_pkg.sv
// funcn_sweep_pkg
//   Shared definitions for the function-block sweep sequencer:
//   - FSM state encodings (IDLE, SETTLE, SAMPLE, DONE)
//   - default function input width
//   Imported by funcn_sweep_ctrl and funcn_settle_cnt.
package funcn_sweep_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/funcn_settle_cnt.sv
// funcn_settle_cnt
//   Loadable down-counter used to time the settle interval.
//   A load takes priority. Otherwise the count decrements until it reaches
//   zero and then rests there.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   load   in  load value into the counter
//   value  in  W-bit load value
//   zero   out counter is zero
module funcn_settle_cnt
  import funcn_sweep_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/funcn_sweep_ctrl.sv
// funcn_sweep_ctrl
//   Hardware sweep of a combinational function block. The block walks fn_in
//   through 0..2^N-1. It holds each code for SETTLE cycles and then samples
//   fn_out into table_out. Each sample is compared with the expected table.
//   A mismatch count and a pass flag summarise the sweep.
//   Optional build macro: FUNCN_SWEEP_EARLY_STOP_EN. When it is defined, the
//   first mismatching sample ends the sweep.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         sweep request, only honoured in IDLE
//   expected      2^N-bit expected truth table, bit i = f(i)
//   fn_in         N-bit registered drive into the function block
//   fn_out        function block output
//   busy          high in SETTLE and SAMPLE
//   done          one-cycle pulse while in DONE
//   table_out     captured truth table
//   mismatch_cnt  N+1-bit count of mismatching entries
//   pass          mismatch_cnt==0, valid from done until the next start
//   state_dbg     current FSM state (encodings in funcn_sweep_pkg)
// Handshake: start is a level-sampled request in IDLE. There is no
//   backpressure. Requests arriving in any other state are dropped.
module funcn_sweep_ctrl
  import funcn_sweep_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [(1<<N)-1:0]   expected,
  output logic [N-1:0]        fn_in,
  input  logic                fn_out,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   table_out,
  output logic [N:0]          mismatch_cnt,
  output logic                pass,
  output logic [1:0]          state_dbg
);

  localparam int TBL = 1 << N;
  localparam int CW  = $clog2(SETTLE) + 1;

  logic [1:0] state;
  logic       settle_zero;
  logic       cnt_load;
  logic       sample_miss;
  logic       last_idx;
  logic       stop_now;
  logic       finish;
  logic [N:0] cnt_next;

  assign sample_miss = (fn_out != expected[fn_in]);
  assign last_idx    = (fn_in == N'(TBL - 1));
  assign cnt_next    = mismatch_cnt + (N+1)'(sample_miss);

`ifdef FUNCN_SWEEP_EARLY_STOP_EN
  assign stop_now = sample_miss;
`else
  assign stop_now = 1'b0;
`endif

  assign finish = last_idx || stop_now;

  // The counter is reloaded when a sweep is accepted and on every advance to
  // the next code. The counter then reaches zero on the last SETTLE cycle.
  assign cnt_load = ((state == ST_IDLE) && start) ||
                    ((state == ST_SAMPLE) && !finish);

  funcn_settle_cnt #(.W(CW)) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (CW'(SETTLE - 1)),
    .zero  (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      fn_in        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SETTLE;
            fn_in        <= '0;
            busy         <= 1'b1;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_zero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          table_out[fn_in] <= fn_out;
          mismatch_cnt     <= cnt_next;
          if (finish) begin
            // done and pass are registered here so that both are visible
            // during the single DONE cycle.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (cnt_next == '0);
          end else begin
            fn_in <= fn_in + N'(1);
            state <= ST_SETTLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_funcn_sweep_ctrl.sv
module tb_funcn_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with SETTLE=1 ----------------
  logic        start1 = 1'b0;
  logic [15:0] expected1 = '0;
  logic [15:0] func1 = '0;
  logic [3:0]  fn_in1;
  logic        fn_out1;
  logic        busy1, done1, pass1;
  logic [15:0] table1;
  logic [4:0]  cnt1;
  logic [1:0]  st1;

  assign fn_out1 = func1[fn_in1];

  funcn_sweep_ctrl #(.N(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
    .fn_in(fn_in1), .fn_out(fn_out1), .busy(busy1), .done(done1),
    .table_out(table1), .mismatch_cnt(cnt1), .pass(pass1), .state_dbg(st1)
  );

  // ---------------- DUT with SETTLE=3 ----------------
  logic        start3 = 1'b0;
  logic [15:0] expected3 = '0;
  logic [15:0] func3 = '0;
  logic [3:0]  fn_in3;
  logic        fn_out3;
  logic        busy3, done3, pass3;
  logic [15:0] table3;
  logic [4:0]  cnt3;
  logic [1:0]  st3;

  assign fn_out3 = func3[fn_in3];

  funcn_sweep_ctrl #(.N(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected3),
    .fn_in(fn_in3), .fn_out(fn_out3), .busy(busy3), .done(done3),
    .table_out(table3), .mismatch_cnt(cnt3), .pass(pass3), .state_dbg(st3)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the truth table index by index. Each visited index costs settle+1
  // cycles. In the early-stop build the walk ends at the first mismatch.
  typedef struct {
    logic [15:0] tab;
    logic [4:0]  cnt;
    logic        pss;
    int          lat;
    logic [3:0]  fn_last;
  } res_t;

  function automatic res_t model(input logic [15:0] f, input logic [15:0] e, input int settle);
    res_t r;
    r.tab = '0; r.cnt = '0; r.lat = 0; r.fn_last = 4'd15;
    for (int i = 0; i < 16; i++) begin
      r.tab[i] = f[i];
      r.lat += settle + 1;
      if (f[i] != e[i]) begin
        r.cnt++;
`ifdef FUNCN_SWEEP_EARLY_STOP_EN
        r.fn_last = 4'(i);
        break;
`endif
      end
    end
    r.pss = (r.cnt == 0);
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] f;
    logic [15:0] e;
    logic [15:0] tab;
    logic [4:0]  cnt;
    logic        pss;
    int          lat;
    logic [3:0]  fn_last;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver: one sweep on the SETTLE=1 instance ----------------
  task automatic run_sweep1(input string tag, input logic [15:0] f, input logic [15:0] e,
                            input logic [15:0] x_tab, input logic [4:0] x_cnt, input logic x_pass,
                            input int x_lat, input logic [3:0] x_fn, input int poke_at);
    int cyc;
    func1 = f;
    expected1 = e;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    cyc = 0;
    check({tag, "_busy_start"}, {31'd0, busy1}, 32'd1);
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start1 = (cyc == poke_at);
    end
    start1 = 1'b0;
    exp_q.push_back(32'(x_lat));
    check({tag, "_latency"}, 32'(cyc), exp_q.pop_front());
    check({tag, "_table"}, {16'd0, table1}, {16'd0, x_tab});
    check({tag, "_mismatch_cnt"}, {27'd0, cnt1}, {27'd0, x_cnt});
    check({tag, "_pass"}, {31'd0, pass1}, {31'd0, x_pass});
    check({tag, "_busy_done"}, {31'd0, busy1}, 32'd0);
    check({tag, "_fn_in_end"}, {28'd0, fn_in1}, {28'd0, x_fn});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done1}, 32'd0);
    check({tag, "_hold_table"}, {16'd0, table1}, {16'd0, x_tab});
    check({tag, "_hold_pass"}, {31'd0, pass1}, {31'd0, x_pass});
    check({tag, "_hold_fn_in"}, {28'd0, fn_in1}, {28'd0, x_fn});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    res_t r;
    logic [15:0] rf, re;
    int cyc;

    // Spec test-plan vectors: {f, expected, table, cnt, pass, latency, fn_in at end}
    vecs[0] = '{16'h6996, 16'h6996, 16'h6996, 5'd0,  1'b1, 32, 4'd15};
`ifdef FUNCN_SWEEP_EARLY_STOP_EN
    vecs[1] = '{16'h6996, 16'h6997, 16'h0000, 5'd1,  1'b0, 2,  4'd0};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 5'd1,  1'b0, 2,  4'd0};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'h0001, 5'd1,  1'b0, 2,  4'd0};
`else
    vecs[1] = '{16'h6996, 16'h6997, 16'h6996, 5'd1,  1'b0, 32, 4'd15};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 5'd16, 1'b0, 32, 4'd15};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 1'b0, 32, 4'd15};
`endif
    vecs[4] = '{16'h8000, 16'h8000, 16'h8000, 5'd0,  1'b1, 32, 4'd15};

    // Reset state
    #12;
    check("rst_fn_in", {28'd0, fn_in1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_table", {16'd0, table1}, 32'd0);
    check("rst_cnt", {27'd0, cnt1}, 32'd0);
    check("rst_pass", {31'd0, pass1}, 32'd0);
    check("rst_state", {30'd0, st1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      run_sweep1($sformatf("vec%0d", i), vecs[i].f, vecs[i].e, vecs[i].tab, vecs[i].cnt,
                 vecs[i].pss, vecs[i].lat, vecs[i].fn_last, -1);
    end

    // Start pulsed again while busy must be ignored
    r = model(16'h6996, 16'h6996, 1);
    run_sweep1("restart_busy", 16'h6996, 16'h6996, r.tab, r.cnt, r.pss, r.lat, r.fn_last, 10);

    // Randomized sweeps against the model
    for (int k = 0; k < 8; k++) begin
      rf = 16'($urandom);
      case ($urandom_range(0, 2))
        0: re = rf;
        1: re = rf ^ (16'd1 << $urandom_range(0, 15));
        default: re = 16'($urandom);
      endcase
      r = model(rf, re, 1);
      run_sweep1($sformatf("rand%0d", k), rf, re, r.tab, r.cnt, r.pss, r.lat, r.fn_last, -1);
    end

    // SETTLE=3 sweep with a per-cycle fn_in monitor
    func3 = 16'h6996;
    expected3 = 16'h6996;
    r = model(func3, expected3, 3);
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!done3 && cyc < 200) begin
      if (cyc < 64) check($sformatf("s3_fn_in_c%0d", cyc), {28'd0, fn_in3}, 32'(cyc / 4));
      @(negedge clk);
      cyc++;
    end
    check("s3_latency", 32'(cyc), 32'(r.lat));
    check("s3_table", {16'd0, table3}, {16'd0, r.tab});
    check("s3_cnt", {27'd0, cnt3}, {27'd0, r.cnt});
    check("s3_pass", {31'd0, pass3}, {31'd0, r.pss});

    // Asynchronous reset mid-sweep
    func1 = 16'h6996;
    expected1 = 16'h6996;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (fn_in1 != 4'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_5", {28'd0, fn_in1}, 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_fn_in", {28'd0, fn_in1}, 32'd0);
    check("mid_rst_table", {16'd0, table1}, 32'd0);
    check("mid_rst_cnt", {27'd0, cnt1}, 32'd0);
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_state", {30'd0, st1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    r = model(16'h6996, 16'h6996, 1);
    run_sweep1("after_rst", 16'h6996, 16'h6996, r.tab, r.cnt, r.pss, r.lat, r.fn_last, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
